muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit that produces the HI/LO write-port signals for MULT, MULTU, DIV and DIVU. It sits between the execute stage and the HI/LO register file. It accepts one operation per start/busy handshake and returns the 64-bit result as a single-cycle write strobe on both halves. Multiply completes in 2 cycles and divide in 33 cycles; the pipeline may cancel an in-flight operation with flush.

## Interface

Parameters:
- DIV_ITERS, 32, number of restoring-division iterations. Fixed at 32 for 32-bit operands; exposed for verification only.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low (0 = reset).
- start  in  1  operation request; sampled only while busy=0.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  32  rs operand (multiplicand / dividend).
- src_b  in  32  rt operand (multiplier / divisor).
- flush  in  1  synchronous cancel of any in-flight operation.
- busy  out  1  1 while an accepted operation has not finished.
- we_hi  out  1  HI write strobe.
- we_lo  out  1  LO write strobe, always equal to we_hi.
- wd_hi  out  32  HI write data (product[63:32] / remainder).
- wd_lo  out  32  LO write data (product[31:0] / quotient).

## Operation

- States: IDLE, MUL, DIV, DONE. Reset state is IDLE.
- Reset values:
  - busy=0, we_hi=we_lo=0, wd_hi=wd_lo=0.
  - Operand, counter and result registers are cleared.
- IDLE:
  - If start=1 and flush=0, capture op, src_a and src_b.
  - MULT/MULTU go to MUL.
  - DIV/DIVU with src_b≠0 go to DIV and clear the iteration counter.
  - DIV/DIVU with src_b=0 go to DONE with the write suppressed (div-by-zero flag set). HI/LO are left unchanged.
- MUL:
  - 64-bit product of the captured operands: signed for MULT (both operands sign-extended), unsigned for MULTU.
  - Product is registered into {result_hi, result_lo}; next state is DONE.
- DIV:
  - Operands are converted to magnitudes at capture (signed DIV only; DIVU uses raw values).
  - Radix-2 restoring division with a 33-bit partial remainder, one quotient bit per cycle, MSB first.
  - Counter runs 0..31; at count 31 the final quotient/remainder is registered with sign correction, then the state goes to DONE.
  - Signed sign correction: quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0, via natural 32-bit wrap. No exception.
- DONE:
  - we_hi = we_lo = (state==DONE) & ~flush & ~divzero.
  - wd_hi/wd_lo are driven from the result registers and hold their value after DONE until the next result.
  - Next state is always IDLE.
- busy = (state≠IDLE). This covers DONE, so a start seen in DONE is ignored.
- flush:
  - In MUL, DIV or DONE: next state is IDLE, no write, result registers are not updated.
  - In IDLE, flush blocks acceptance of a same-cycle start.
- Asynchronous reset mid-operation: everything returns to reset values immediately and no partial write occurs.

## Timing

- Cycle T is the edge at which start is accepted (IDLE, busy=0).
- Multiply:
  - busy=1 in T+1 and T+2.
  - we strobes are high during T+2 with the product on wd.
  - busy=0 at T+3, when a new start may be accepted.
- Divide:
  - DIV state covers T+1..T+32; DONE (write) is T+33; IDLE at T+34.
- Divide by zero: DONE at T+1 with no strobe; IDLE at T+2.
- Write strobes are exactly one cycle wide per completed operation. There are never two writes without an intervening start.
- Flush asserted in cycle F (non-IDLE): busy=0 from F+1, and start is accepted at F+1 if present.
- All outputs are registered or decoded from the state register alone; there are no combinational paths from src_a, src_b or start to the outputs.

## Test plan

- MULT 0xFFFFFFFF×0x00000002 -> at T+2 we=1, wd_hi=0xFFFFFFFF, wd_lo=0xFFFFFFFE. MULTU on the same operands -> wd_hi=0x00000001, wd_lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) ÷ 2 -> at T+33 wd_lo=0xFFFFFFFD, wd_hi=0xFFFFFFFF. DIVU 100÷7 -> wd_lo=14, wd_hi=2. busy is high for T+1..T+33 in both cases.
- DIV 0x80000000÷0xFFFFFFFF -> wd_lo=0x80000000, wd_hi=0. DIV 7÷0xFFFFFFFE (−2) -> wd_lo=0xFFFFFFFD, wd_hi=1.
- DIVU 5÷0 -> busy=1 only in T+1, no we pulse, busy=0 at T+2; a following MULTU 3×4 writes hi=0, lo=12.
- Start DIV, assert flush at T+10 -> no we pulse ever; busy=0 at T+11. A start at T+11 with MULT 2×3 gives a write of hi=0, lo=6 at T+13.
- Start DIV, drive rst=0 asynchronously at T+5 (between edges) -> busy, we and wd go to 0 immediately, and stay there after rst releases until a new start.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit producing HI/LO write strobes.
// Multiply takes 2 busy cycles. Divide is radix-2 restoring, one bit per cycle.
module muldiv_unit #(
   parameter int unsigned DIV_ITERS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        busy,
   output logic        we_hi,
   output logic        we_lo,
   output logic [31:0] wd_hi,
   output logic [31:0] wd_lo
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = $clog2(DIV_ITERS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [DATA_W-1:0]   a_q, a_d;        // multiplicand, or dividend/quotient shift register
   logic [DATA_W-1:0]   b_q, b_d;        // multiplier, or divisor magnitude
   logic [DATA_W-1:0]   rem_q, rem_d;    // partial remainder
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                neg_q, neg_d;    // quotient must be negated
   logic                rneg_q, rneg_d;  // remainder must be negated
   logic                divz_q, divz_d;  // divide by zero: suppress the write
   logic [DATA_W-1:0]   res_hi_q, res_hi_d;
   logic [DATA_W-1:0]   res_lo_q, res_lo_d;

   logic                in_signed;
   logic [DATA_W-1:0]   a_mag, b_mag;
   logic [2*DATA_W-1:0] ext_a, ext_b, product;
   logic [DATA_W:0]     rem_shift, rem_diff;
   logic [DATA_W-1:0]   rem_step, quot_step;

   // Operand magnitudes for signed divide, taken at capture
   always_comb begin
      in_signed = ~op[0];
      a_mag = (in_signed && src_a[31]) ? (-src_a) : src_a;
      b_mag = (in_signed && src_b[31]) ? (-src_b) : src_b;
   end

   // 64-bit product; sign extension gives the signed result in the low 64 bits
   always_comb begin
      ext_a   = op_q[0] ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
      ext_b   = op_q[0] ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
      product = ext_a * ext_b;
   end

   // One restoring-division step: shift in the next dividend bit, trial subtract
   always_comb begin
      rem_shift = {rem_q, a_q[31]};
      rem_diff  = rem_shift - {1'b0, b_q};
      if (!rem_diff[DATA_W]) begin
         rem_step  = rem_diff[DATA_W-1:0];
         quot_step = {a_q[DATA_W-2:0], 1'b1};
      end else begin
         rem_step  = rem_shift[DATA_W-1:0];
         quot_step = {a_q[DATA_W-2:0], 1'b0};
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      divz_d   = divz_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               op_d   = op;
               divz_d = 1'b0;
               if (!op[1]) begin
                  a_d     = src_a;
                  b_d     = src_b;
                  state_d = S_MUL;
               end else begin
                  a_d    = a_mag;
                  b_d    = b_mag;
                  neg_d  = in_signed & (src_a[31] ^ src_b[31]);
                  rneg_d = in_signed & src_a[31];
                  rem_d  = '0;
                  cnt_d  = '0;
                  if (src_b == '0) begin
                     divz_d  = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     state_d = S_DIV;
                  end
               end
            end
         end
         S_MUL: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               res_hi_d = product[2*DATA_W-1:DATA_W];
               res_lo_d = product[DATA_W-1:0];
               state_d  = S_DONE;
            end
         end
         S_DIV: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               a_d   = quot_step;
               rem_d = rem_step;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  res_lo_d = neg_q  ? (-quot_step) : quot_step;
                  res_hi_d = rneg_q ? (-rem_step)  : rem_step;
                  state_d  = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand, counter and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         divz_q   <= 1'b0;
         res_hi_q <= '0;
         res_lo_q <= '0;
      end else begin
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         divz_q   <= divz_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
      end
   end

   // Outputs decoded from state and result registers; flush kills a DONE write
   always_comb begin
      busy  = (state_q != S_IDLE);
      we_hi = (state_q == S_DONE) & ~flush & ~divz_q;
      we_lo = we_hi;
      wd_hi = res_hi_q;
      wd_lo = res_lo_q;
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed literal cases plus random traffic vs a cycle-count model.
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        busy;
   logic        we_hi;
   logic        we_lo;
   logic [31:0] wd_hi;
   logic [31:0] wd_lo;

   int n_cmp = 0;
   int n_bad = 0;

   muldiv_unit #(.DIV_ITERS(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .flush (flush),
      .busy  (busy),
      .we_hi (we_hi),
      .we_lo (we_lo),
      .wd_hi (wd_hi),
      .wd_lo (wd_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result {HI, LO} from plain arithmetic
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, p, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = '0;
      case (o)
         2'd0: begin p = sa * sb; res = p; end
         2'd1: res = {32'd0, a} * {32'd0, b};
         2'd2: begin
            if (b != 0) begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: if (b != 0) res = {a % b, a / b};
      endcase
      return res;
   endfunction

   // Model: cycles left until idle, pending result, last written result
   int          left_m;
   logic        div0_m;
   logic [63:0] pend_m;
   logic [63:0] last_m;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         left_m = 0;
         div0_m = 1'b0;
         pend_m = '0;
         last_m = '0;
      end else if (left_m == 0) begin
         if (start && !flush) begin
            pend_m = ref_result(op, src_a, src_b);
            div0_m = op[1] && (src_b == 0);
            left_m = !op[1] ? 2 : (src_b == 0 ? 1 : 33);
         end
      end else if (flush) begin
         left_m = 0;
      end else begin
         if (left_m == 2 && !div0_m) last_m = pend_m;
         left_m = left_m - 1;
      end
   end

   // Per-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (rst) begin
         check("busy", 64'(busy), 64'(left_m > 0));
         check("we_hi", 64'(we_hi), 64'(left_m == 1 && !div0_m && !flush));
         check("we_lo", 64'(we_lo), 64'(left_m == 1 && !div0_m && !flush));
         check("wd", {wd_hi, wd_lo}, last_m);
      end
   end

   // Issue one op from idle, expect a write at cycle lat with literal data
   task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] eh,
                        input logic [31:0] el);
      int k;
      bit seen;
      for (int i = 0; i < 50 && busy; i++) @(negedge clk);
      #1;
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(negedge clk);
      #1 start = 1'b0;
      k = 1;
      seen = 1'b0;
      while (k <= 40) begin
         if (we_hi) begin seen = 1'b1; break; end
         check({name, "_busy"}, 64'(busy), 64'd1);
         @(negedge clk);
         k++;
      end
      if (!seen) begin
         check({name, "_timeout"}, 64'd0, 64'd1);
      end else begin
         check({name, "_lat"}, 64'(k), 64'(lat));
         check({name, "_hi"}, 64'(wd_hi), 64'(eh));
         check({name, "_lo"}, 64'(wd_lo), 64'(el));
         @(negedge clk);
         check({name, "_idle"}, 64'(busy), 64'd0);
      end
   endtask

   initial begin
      int wes;
      rst = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; flush = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_we", 64'({we_hi, we_lo}), 64'd0);
      check("rst_wd", {wd_hi, wd_lo}, 64'd0);
      check("model_div_ovf", ref_result(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
      check("model_mult", ref_result(2'd0, 32'hFFFF_FFFF, 32'd2), 64'hFFFF_FFFF_FFFF_FFFE);
      #1 rst = 1'b1;
      @(negedge clk);

      do_op("mult",   2'd0, 32'hFFFF_FFFF, 32'd2, 2,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
      do_op("multu",  2'd1, 32'hFFFF_FFFF, 32'd2, 2,  32'h0000_0001, 32'hFFFF_FFFE);
      do_op("div_n7", 2'd2, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      do_op("divu",   2'd3, 32'd100, 32'd7,       33, 32'd2,         32'd14);
      do_op("div_ov", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
      do_op("div_nb", 2'd2, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);

      // Divide by zero: one busy cycle, no strobe
      #1 start = 1'b1; op = 2'd3; src_a = 32'd5; src_b = 32'd0;
      @(negedge clk);
      #1 start = 1'b0;
      check("dz_busy1", 64'(busy), 64'd1);
      check("dz_we", 64'(we_hi), 64'd0);
      @(negedge clk);
      check("dz_busy2", 64'(busy), 64'd0);
      do_op("dz_multu", 2'd1, 32'd3, 32'd4, 2, 32'd0, 32'd12);

      // Flush mid-divide, then a multiply restarts right away
      #1 start = 1'b1; op = 2'd2; src_a = 32'd1000; src_b = 32'd3;
      wes = 0;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if (we_hi) wes++;
         #1 start = 1'b0;
         flush = (k == 9);
      end
      flush = 1'b0;
      check("fl_nowe", 64'(wes), 64'd0);
      check("fl_busy", 64'(busy), 64'd0);
      #1 start = 1'b1; op = 2'd0; src_a = 32'd2; src_b = 32'd3;
      @(negedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("fl_mul_we", 64'(we_hi), 64'd1);
      check("fl_mul_wd", {wd_hi, wd_lo}, 64'd6);
      @(negedge clk);

      // Async reset in the middle of a divide
      #1 start = 1'b1; op = 2'd2; src_a = 32'd77; src_b = 32'd5;
      @(negedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("ar_busy", 64'(busy), 64'd0);
      check("ar_we", 64'({we_hi, we_lo}), 64'd0);
      check("ar_wd", {wd_hi, wd_lo}, 64'd0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("ar_hold", {wd_hi, wd_lo}, 64'd0);

      // Random traffic, checked every cycle by the model
      for (int c = 0; c < 3000; c++) begin
         #1;
         start = ($urandom_range(0, 3) != 0);
         op    = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 7))
            0: src_a = 32'h8000_0000;
            1: src_a = 32'hFFFF_FFFF;
            2: src_a = 32'($urandom_range(0, 20));
            default: src_a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: src_b = 32'd0;
            1: src_b = 32'hFFFF_FFFF;
            2: src_b = 32'($urandom_range(1, 20));
            default: src_b = $urandom;
         endcase
         flush = ($urandom_range(0, 39) == 0);
         @(negedge clk);
      end
      #1 start = 1'b0; flush = 1'b0;
      repeat (40) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
